// File: rtl/crc16_tx_framer_if.sv
// Handshake, serial stream and status signals of the CRC-16 transmit framer.
// The framer connects through the slave modport, its driver through master.
interface crc16_tx_framer_if #(
    parameter int unsigned LEN_W = 6
);
    logic             go;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic             tx_en;
    logic             tx_bit;
    logic             tx_valid;
    logic             tx_last;
    logic             busy;
    logic             done;
    logic [15:0]      crc_out;

    modport master (
        output go, frame_len, in_byte, in_valid, tx_en,
        input  in_ready, tx_bit, tx_valid, tx_last, busy, done, crc_out
    );

    modport slave (
        input  go, frame_len, in_byte, in_valid, tx_en,
        output in_ready, tx_bit, tx_valid, tx_last, busy, done, crc_out
    );
endinterface

// File: rtl/crc16_tx_framer.sv
// Serializes payload bytes MSB first and appends a CRC-16 (poly 0x8005, no reflection),
// so a matching serial checker preset to CRC_INIT ends the frame at zero.
module crc16_tx_framer #(
    parameter int unsigned LEN_W    = 6,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input logic              clck,
    input logic              start,
    crc16_tx_framer_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StData, StCrc, StDone} state_e;

    state_e           state_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [15:0]      out_shift_q;
    logic [15:0]      crc_q;
    logic [15:0]      crc_d;
    logic [15:0]      crc_out_q;
    logic             fb;
    logic             in_ready_q;
    logic             tx_valid_q;
    logic             tx_last_q;
    logic             busy_q;
    logic             done_q;

    always_comb begin
        fb    = crc_q[15] ^ shift_q[7];
        crc_d = {crc_q[14] ^ fb, crc_q[13:2], crc_q[1] ^ fb, crc_q[0], fb};
    end

    always_ff @(posedge clck) begin
        if (start) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_shift_q <= '0;
            crc_q       <= CRC_INIT;
            crc_out_q   <= '0;
            in_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.go) begin
                        byte_cnt_q <= bus.frame_len;
                        crc_q      <= CRC_INIT;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        // An empty frame sends only the preset CRC.
                        if (bus.frame_len == '0) begin
                            state_q     <= StCrc;
                            out_shift_q <= CRC_INIT;
                            crc_out_q   <= CRC_INIT;
                            tx_valid_q  <= 1'b1;
                        end else begin
                            state_q    <= StLoad;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        shift_q    <= bus.in_byte;
                        bit_cnt_q  <= '0;
                        state_q    <= StData;
                        in_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                    end
                end
                StData: begin
                    if (bus.tx_en) begin
                        crc_q     <= crc_d;
                        shift_q   <= {shift_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= byte_cnt_q - LEN_W'(1);
                            if (byte_cnt_q == LEN_W'(1)) begin
                                state_q     <= StCrc;
                                out_shift_q <= crc_d;
                                crc_out_q   <= crc_d;
                            end else begin
                                state_q    <= StLoad;
                                in_ready_q <= 1'b1;
                                tx_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                StCrc: begin
                    if (bus.tx_en) begin
                        out_shift_q <= {out_shift_q[14:0], 1'b0};
                        bit_cnt_q   <= bit_cnt_q + 4'd1;
                        tx_last_q   <= (bit_cnt_q == 4'd14);
                        if (bit_cnt_q == 4'd15) begin
                            state_q    <= StDone;
                            bit_cnt_q  <= '0;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tx_bit   = (state_q == StData) ? shift_q[7] :
                          (state_q == StCrc)  ? out_shift_q[15] : 1'b0;
    assign bus.in_ready = in_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_last  = tx_last_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crc_out  = crc_out_q;
endmodule

// File: tb/tb_crc16_tx_framer.sv
// Directed bench for crc16_tx_framer: captures the consumed bit stream, replays it
// through a serial CRC checker and compares against hand-derived frames.
module tb_crc16_tx_framer;
    localparam int unsigned LEN_W = 6;

    logic clck = 1'b0;
    logic start;
    always #5 clck = ~clck;

    crc16_tx_framer_if #(.LEN_W(LEN_W)) bus ();

    crc16_tx_framer #(.LEN_W(LEN_W), .CRC_INIT(16'hFFFF)) dut (
        .clck  (clck),
        .start (start),
        .bus   (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          rand_en = 1'b0;
    bit          bits_q[$];
    int unsigned done_seen, last_cnt, last_pos, in_ready_cycles;
    logic [15:0] chk_reg;
    logic [7:0]  payload [0:63];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial sink: consumes whenever tx_en is high, optionally randomized.
    initial begin
        bus.tx_en = 1'b1;
        forever begin
            @(posedge clck);
            #1;
            bus.tx_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor and receiver-side checker register.
    initial begin
        logic fb;
        forever begin
            @(negedge clck);
            if (bus.tx_valid && bus.tx_en) begin
                if (bus.tx_last) begin
                    last_cnt++;
                    last_pos = bits_q.size();
                end
                bits_q.push_back(bus.tx_bit);
                fb      = chk_reg[15] ^ bus.tx_bit;
                chk_reg = {chk_reg[14] ^ fb, chk_reg[13:2], chk_reg[1] ^ fb, chk_reg[0], fb};
            end
            if (bus.done) done_seen++;
            if (bus.in_ready) in_ready_cycles++;
        end
    end

    task automatic clear_mon();
        bits_q.delete();
        done_seen       = 0;
        last_cnt        = 0;
        last_pos        = 0;
        in_ready_cycles = 0;
        chk_reg         = 16'hFFFF;
    endtask

    task automatic feed_byte(input logic [7:0] b, input int unsigned dly, output bit ok);
        repeat (dly) begin
            @(posedge clck);
            #1;
        end
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clck);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clck);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int unsigned len, input int unsigned dly_max);
        bit ok;
        clear_mon();
        bus.frame_len = LEN_W'(len);
        bus.go = 1'b1;
        @(posedge clck);
        #1;
        bus.go = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            feed_byte(payload[i], (dly_max == 0) ? 0 : $urandom_range(0, dly_max), ok);
            check_eq({tag, "_accept"}, 32'(ok), 32'd1);
        end
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clck);
            #1;
            if (done_seen != 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done_timeout"}, 32'(ok), 32'd1);
        repeat (3) begin
            @(posedge clck);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input int unsigned len, input bit has_crc,
                               input logic [15:0] exp_crc);
        int unsigned nerr = 0;
        int unsigned nb   = 8 * len + 16;
        check_eq({tag, "_nbits"}, bits_q.size(), nb);
        if (bits_q.size() == nb) begin
            for (int unsigned i = 0; i < 8 * len; i++)
                if (bits_q[i] != payload[i / 8][7 - (i % 8)]) nerr++;
            if (has_crc)
                for (int unsigned j = 0; j < 16; j++)
                    if (bits_q[8 * len + j] != exp_crc[15 - j]) nerr++;
        end
        check_eq({tag, "_bitseq_errs"}, nerr, 32'd0);
        if (has_crc) check_eq({tag, "_crc_out"}, 32'(bus.crc_out), 32'(exp_crc));
        check_eq({tag, "_checker_reg"}, 32'(chk_reg), 32'h0);
        check_eq({tag, "_done_cnt"}, done_seen, 32'd1);
        check_eq({tag, "_tx_last_cnt"}, last_cnt, 32'd1);
        check_eq({tag, "_tx_last_pos"}, last_pos, nb - 1);
        check_eq({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_tx_valid_end"}, 32'(bus.tx_valid), 32'd0);
    endtask

    task automatic load_check_string();
        for (int i = 0; i < 9; i++) payload[i] = 8'(8'h31 + i);
    endtask

    initial begin
        bit ok;
        start         = 1'b1;
        bus.go        = 1'b0;
        bus.frame_len = '0;
        bus.in_byte   = '0;
        bus.in_valid  = 1'b0;
        clear_mon();
        repeat (2) @(posedge clck);
        #1;
        start = 1'b0;

        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("rst_tx_bit", 32'(bus.tx_bit), 32'd0);
        check_eq("rst_tx_last", 32'(bus.tx_last), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_crc_out", 32'(bus.crc_out), 32'd0);

        load_check_string();
        run_frame("str", 9, 0);
        check_frame("str", 9, 1'b1, 16'hAEE7);

        clear_mon();
        run_frame("zero", 0, 0);
        check_frame("zero", 0, 1'b1, 16'hFFFF);
        check_eq("zero_in_ready_cycles", in_ready_cycles, 32'd0);

        for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
        run_frame("loop4", 4, 0);
        check_frame("loop4", 4, 1'b0, 16'h0);

        for (int i = 0; i < 63; i++) payload[i] = 8'($urandom);
        run_frame("max63", 63, 0);
        check_frame("max63", 63, 1'b0, 16'h0);

        load_check_string();
        rand_en = 1'b1;
        run_frame("stall", 9, 5);
        rand_en = 1'b0;
        check_frame("stall", 9, 1'b1, 16'hAEE7);

        // Abort during the third byte of a nine-byte frame.
        clear_mon();
        bus.frame_len = LEN_W'(9);
        bus.go = 1'b1;
        @(posedge clck);
        #1;
        bus.go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            feed_byte(payload[i], 0, ok);
            check_eq("abort_accept", 32'(ok), 32'd1);
        end
        repeat (2) begin
            @(posedge clck);
            #1;
        end
        start = 1'b1;
        @(posedge clck);
        #1;
        start = 1'b0;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("abort_crc_out", 32'(bus.crc_out), 32'd0);
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (20) @(posedge clck);
        #1;
        check_eq("abort_no_done", done_seen, 32'd0);
        run_frame("after_abort", 9, 0);
        check_frame("after_abort", 9, 1'b1, 16'hAEE7);

        fork
            run_frame("go_busy", 9, 0);
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clck);
                    if (bus.tx_valid) break;
                end
                @(posedge clck);
                #1;
                bus.frame_len = LEN_W'(2);
                bus.go = 1'b1;
                @(posedge clck);
                #1;
                bus.go = 1'b0;
            end
        join
        check_frame("go_busy", 9, 1'b1, 16'hAEE7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/crc16_tx_framer.md
Name: crc16_tx_framer

Overview:
Transmit-side companion of the serial CRC-16 checker. Accepts payload bytes over a valid/ready handshake and serializes them MSB first onto a bit stream. Computes CRC-16 on the fly: polynomial x^16+x^15+x^2+1 (0x8005), init 0xFFFF, no reflection, no final XOR. Appends the 16 CRC bits MSB first, so the receiver's register reads 0x0000 after the full frame.

Parameters:
LEN_W, 6, width of frame_len; payload length is 0..2^LEN_W-1 bytes
CRC_INIT, 16'hFFFF, CRC register preset at frame start

Ports:
clck  input  1  clock, all logic on rising edge
start  input  1  reset; synchronous, active-high
go  input  1  one-cycle frame request; sampled only in IDLE
frame_len  input  LEN_W  payload byte count, latched on accepted go
in_byte  input  8  payload byte
in_valid  input  1  in_byte valid
in_ready  output  1  framer accepts in_byte this cycle
tx_en  input  1  serial sink consumes tx_bit this cycle
tx_bit  output  1  current serial bit
tx_valid  output  1  tx_bit is meaningful
tx_last  output  1  tx_bit is the final CRC bit
busy  output  1  frame in progress, high in every state except IDLE
done  output  1  one-cycle pulse after the last CRC bit is consumed
crc_out  output  16  final CRC of the last frame, held until the next go

Behaviour:
- Reset (start=1 at a clock edge), whether idle or mid-frame:
  - state goes to IDLE; the frame is abandoned with no done pulse.
  - Outputs: in_ready=0, tx_valid=0, tx_bit=0, tx_last=0, busy=0, done=0, crc_out=0.
  - CRC register set to CRC_INIT; byte and bit counters cleared.
- FSM states: IDLE, LOAD, DATA, CRC, DONE.
- IDLE:
  - On go=1: latch frame_len into the byte counter and preset the CRC register to CRC_INIT.
  - Next state is CRC if frame_len=0, else LOAD.
  - go while not in IDLE is ignored.
- LOAD:
  - in_ready=1 and tx_valid=0.
  - When in_valid=1 at the edge: in_byte goes into the 8-bit shift register, bit counter=0, next state DATA.
  - Otherwise the FSM waits indefinitely.
- DATA:
  - tx_valid=1; tx_bit=shift[7], driven combinationally from the register.
  - On a cycle with tx_en=1:
    - CRC update with d=tx_bit, fb=R[15]^d. R[0]<=fb; R[1]<=R[0]; R[2]<=R[1]^fb; R[14:3]<=R[13:2]; R[15]<=R[14]^fb.
    - Shift register moves left one place; bit counter increments.
  - tx_en=0 stalls: shift register, CRC and counters all hold.
  - After the 8th consumed bit, the byte counter decrements. Next state is LOAD if the count is still nonzero, else CRC.
  - There is at least one idle cycle (tx_valid=0) between bytes.
- CRC:
  - On entry, the CRC register is copied into a 16-bit out-shift register and into crc_out.
  - tx_valid=1; tx_bit=out_shift[15]. Each tx_en=1 cycle shifts left one place, zero fill.
  - tx_last=1 while the 16th bit is presented.
  - After the 16th consumed bit, next state is DONE.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
- in_valid outside LOAD is ignored; in_ready is 0 in every state except LOAD.
- Bits presented per frame = 8*frame_len+16. tx_valid falls the cycle after the last CRC bit is consumed.
- Byte counter is LEN_W wide; frame_len=2^LEN_W-1 is supported with no wrap.

Test Plan:
- Check string: go with frame_len=9, bytes "123456789" (0x31..0x39), tx_en tied 1 -> crc_out=0xAEE7; the last 16 tx_bits are 1010111011100111; done pulses once; total bits consumed =88.
- Zero-length frame: go, frame_len=0 -> no in_ready; 16 bits all 1 (0xFFFF) with tx_last on the 16th; crc_out=0xFFFF.
- Loopback: feed tx_bit (gated by tx_en) into the serial CRC checker preset to 0xFFFF, frame of 4 random bytes -> checker register =0x0000 after the last bit.
- Stalls and back-pressure: random tx_en 50% and in_valid delayed 0-5 cycles on the "123456789" frame -> bit sequence identical to the unstalled run; crc_out=0xAEE7.
- Reset mid-frame: assert start for 1 cycle during byte 3 of a 9-byte frame -> next cycle busy=0, tx_valid=0, crc_out=0, no done. A new go with "123456789" then yields 0xAEE7.
- go ignored while busy: pulse go with frame_len=2 during DATA of a 9-byte frame -> frame completes with 88 bits and crc_out=0xAEE7.
